// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: EX-stage bus widths, aluop/alufun encodings, divider state type and an abs helper
package ex_stage_pkg;
   localparam int REG_W = 32;
   localparam int ALUOP_W = 3;
   localparam int ALUFUN_W = 4;
   localparam int REGADDR_W = 5;
   localparam logic [ALUOP_W-1:0] OP_NOP = 3'd0;
   localparam logic [ALUOP_W-1:0] OP_LOGIC = 3'd1;
   localparam logic [ALUOP_W-1:0] OP_SHIFT = 3'd2;
   localparam logic [ALUOP_W-1:0] OP_ARITH = 3'd3;
   localparam logic [ALUOP_W-1:0] OP_MULDIV = 3'd4;
   localparam logic [ALUFUN_W-1:0] F_AND = 4'd0;
   localparam logic [ALUFUN_W-1:0] F_OR = 4'd1;
   localparam logic [ALUFUN_W-1:0] F_XOR = 4'd2;
   localparam logic [ALUFUN_W-1:0] F_SLL = 4'd0;
   localparam logic [ALUFUN_W-1:0] F_SRL = 4'd1;
   localparam logic [ALUFUN_W-1:0] F_SRA = 4'd2;
   localparam logic [ALUFUN_W-1:0] F_ADD = 4'd0;
   localparam logic [ALUFUN_W-1:0] F_SUB = 4'd1;
   localparam logic [ALUFUN_W-1:0] F_SLT = 4'd2;
   localparam logic [ALUFUN_W-1:0] F_SLTU = 4'd3;
   localparam logic [ALUFUN_W-1:0] F_MUL = 4'd0;
   localparam logic [ALUFUN_W-1:0] F_MULH = 4'd1;
   localparam logic [ALUFUN_W-1:0] F_MULHSU = 4'd2;
   localparam logic [ALUFUN_W-1:0] F_MULHU = 4'd3;
   localparam logic [ALUFUN_W-1:0] F_DIV = 4'd4;
   localparam logic [ALUFUN_W-1:0] F_DIVU = 4'd5;
   localparam logic [ALUFUN_W-1:0] F_REM = 4'd6;
   localparam logic [ALUFUN_W-1:0] F_REMU = 4'd7;
   typedef enum logic [1:0] {DIV_IDLE = 2'd0, DIV_BUSY = 2'd1, DIV_DONE = 2'd2} div_state_e;
   function automatic logic [REG_W-1:0] abs_val(input logic sgn, input logic [REG_W-1:0] v);
      return (sgn && v[REG_W-1]) ? -v : v;
   endfunction
endpackage

// File: rtl/ex_div.sv
// ex_div: 32-step restoring divider; in: clk rst start sgn dividend divisor abort; out: busy done quotient remainder
module ex_div
   import ex_stage_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sgn,
   input  logic [REG_W-1:0] dividend,
   input  logic [REG_W-1:0] divisor,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic [REG_W-1:0] quotient,
   output logic [REG_W-1:0] remainder
);
   div_state_e state;
   logic [4:0] cnt;
   logic [REG_W-1:0] quo, rem, dvs;
   logic neg_q, neg_r, ge;
   logic [REG_W:0] t;
   assign t = {rem, quo[REG_W-1]};
   assign ge = t >= {1'b0, dvs};
   assign busy = state == DIV_BUSY;
   assign done = state == DIV_DONE;
   assign quotient = neg_q ? -quo : quo;
   assign remainder = neg_r ? -rem : rem;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= DIV_IDLE;
         cnt <= '0;
         quo <= '0;
         rem <= '0;
         dvs <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (abort) begin
         state <= DIV_IDLE;
      end else begin
         case (state)
            DIV_IDLE: if (start) begin
               state <= DIV_BUSY;
               cnt <= '0;
               quo <= abs_val(sgn, dividend);
               dvs <= abs_val(sgn, divisor);
               rem <= '0;
               neg_q <= sgn & (dividend[REG_W-1] ^ divisor[REG_W-1]);
               neg_r <= sgn & dividend[REG_W-1];
            end
            DIV_BUSY: begin
               quo <= {quo[REG_W-2:0], ge};
               rem <= ge ? t[REG_W-1:0] - dvs : t[REG_W-1:0];
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31) state <= DIV_DONE;
            end
            default: state <= DIV_IDLE;
         endcase
      end
   end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage ALU/shift/mul with iterative divide; in: clk rst aluop_i alufun_i reg1_i reg2_i wd_i wreg_i flush_i; out: wd_o wreg_o wdata_o stallreq_o
module ex_stage
   import ex_stage_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ALUOP_W-1:0]   aluop_i,
   input  logic [ALUFUN_W-1:0]  alufun_i,
   input  logic [REG_W-1:0]     reg1_i,
   input  logic [REG_W-1:0]     reg2_i,
   input  logic [REGADDR_W-1:0] wd_i,
   input  logic                 wreg_i,
   input  logic                 flush_i,
   output logic [REGADDR_W-1:0] wd_o,
   output logic                 wreg_o,
   output logic [REG_W-1:0]     wdata_o,
   output logic                 stallreq_o
);
   logic [REG_W-1:0] a, b, logic_res, shift_res, arith_res, mul_res, div_res, md_res, res, quo, rem;
   logic [2*REG_W-1:0] ea, eb, prod;
   logic div_op, sgn, is_rem, zero_div, ovf, start, busy, done;
   assign a = reg1_i;
   assign b = reg2_i;
   assign logic_res = alufun_i == F_AND ? a & b :
                      alufun_i == F_OR  ? a | b :
                      alufun_i == F_XOR ? a ^ b : '0;
   assign shift_res = alufun_i == F_SLL ? a << b[4:0] :
                      alufun_i == F_SRL ? a >> b[4:0] :
                      alufun_i == F_SRA ? REG_W'($signed(a) >>> b[4:0]) : '0;
   assign arith_res = alufun_i == F_ADD  ? a + b :
                      alufun_i == F_SUB  ? a - b :
                      alufun_i == F_SLT  ? {31'b0, $signed(a) < $signed(b)} :
                      alufun_i == F_SLTU ? {31'b0, a < b} : '0;
   assign ea = {{REG_W{alufun_i != F_MULHU && a[REG_W-1]}}, a};
   assign eb = {{REG_W{alufun_i == F_MULH && b[REG_W-1]}}, b};
   assign prod = ea * eb;
   assign mul_res = alufun_i == F_MUL ? prod[REG_W-1:0] : prod[2*REG_W-1:REG_W];
   assign div_op = aluop_i == OP_MULDIV && alufun_i[3:2] == 2'b01;
   assign sgn = alufun_i == F_DIV || alufun_i == F_REM;
   assign is_rem = alufun_i == F_REM || alufun_i == F_REMU;
   assign zero_div = b == '0;
   assign ovf = sgn && a == 32'h8000_0000 && b == '1;
   assign start = div_op && !zero_div && !ovf && !flush_i;
   assign div_res = zero_div ? (is_rem ? a : '1) :
                    ovf      ? (is_rem ? '0 : 32'h8000_0000) :
                    (done && !flush_i) ? (is_rem ? rem : quo) : '0;
   assign md_res = alufun_i[3] ? '0 : alufun_i[2] ? div_res : mul_res;
   assign res = aluop_i == OP_LOGIC  ? logic_res :
                aluop_i == OP_SHIFT  ? shift_res :
                aluop_i == OP_ARITH  ? arith_res :
                aluop_i == OP_MULDIV ? md_res : '0;
   assign stallreq_o = !rst && !flush_i && (busy || (start && !done));
   assign wdata_o = (rst || stallreq_o) ? '0 : res;
   assign wd_o = rst ? '0 : wd_i;
   assign wreg_o = !rst && !stallreq_o && wreg_i;
   ex_div u_div (
      .clk(clk),
      .rst(rst),
      .start(start),
      .sgn(sgn),
      .dividend(a),
      .divisor(b),
      .abort(flush_i),
      .busy(busy),
      .done(done),
      .quotient(quo),
      .remainder(rem)
   );
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: scoreboard bench for ex_stage ALU, multiply, divide, flush and reset behaviour
module tb_ex_stage;
   import ex_stage_pkg::*;
   logic clk = 1'b0, rst = 1'b1, wreg_i = 1'b0, flush_i = 1'b0;
   logic [2:0] aluop_i = '0;
   logic [3:0] alufun_i = '0;
   logic [31:0] reg1_i = '0, reg2_i = '0;
   logic [4:0] wd_i = '0;
   logic [4:0] wd_o;
   logic wreg_o, stallreq_o;
   logic [31:0] wdata_o;
   typedef struct packed {logic [31:0] wdata; logic dchk; logic [4:0] wd; logic wreg; logic stall;} exp_t;
   typedef struct packed {logic [2:0] op; logic [3:0] f; logic [31:0] a; logic [31:0] b;} vec_t;
   typedef struct packed {logic [3:0] f; logic [31:0] a; logic [31:0] b; logic [31:0] q; logic gap;} dv_t;
   exp_t sb[$];
   exp_t e;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   ex_stage dut (
      .clk(clk), .rst(rst), .aluop_i(aluop_i), .alufun_i(alufun_i), .reg1_i(reg1_i), .reg2_i(reg2_i),
      .wd_i(wd_i), .wreg_i(wreg_i), .flush_i(flush_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
      .stallreq_o(stallreq_o)
   );
   task automatic drive(input logic [2:0] op, input logic [3:0] f, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] d, input logic w);
      aluop_i = op; alufun_i = f; reg1_i = x; reg2_i = y; wd_i = d; wreg_i = w;
   endtask
   function automatic logic [31:0] model(input logic [2:0] op, input logic [3:0] f, input logic [31:0] x, input logic [31:0] y);
      longint ss, su;
      longint unsigned uu;
      ss = longint'($signed(x)) * longint'($signed(y));
      su = longint'($signed(x)) * longint'({32'b0, y});
      uu = {32'b0, x} * {32'b0, y};
      case ({op, f})
         {3'd1, 4'd0}: return x & y;
         {3'd1, 4'd1}: return x | y;
         {3'd1, 4'd2}: return x ^ y;
         {3'd2, 4'd0}: return x << y[4:0];
         {3'd2, 4'd1}: return x >> y[4:0];
         {3'd2, 4'd2}: return 32'($signed(x) >>> y[4:0]);
         {3'd3, 4'd0}: return x + y;
         {3'd3, 4'd1}: return x - y;
         {3'd3, 4'd2}: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         {3'd3, 4'd3}: return (x < y) ? 32'd1 : 32'd0;
         {3'd4, 4'd0}: return ss[31:0];
         {3'd4, 4'd1}: return ss[63:32];
         {3'd4, 4'd2}: return su[63:32];
         {3'd4, 4'd3}: return uu[63:32];
         default: return 32'd0;
      endcase
   endfunction
   task automatic test_reset;
      drive(OP_ARITH, F_ADD, 32'd1, 32'd1, 5'd3, 1'b1);
      for (int c = 0; c < 2; c++) begin
         sb.push_back('{32'd0, 1'b1, 5'd0, 1'b0, 1'b0});
         @(negedge clk);
         e = sb.pop_front(); checks++;
         if (stallreq_o !== e.stall || wreg_o !== e.wreg || wd_o !== e.wd || (e.dchk && wdata_o !== e.wdata)) begin
            errors++;
            $display("FAIL reset[%0d]: got stall=%b wreg=%b wd=%0d wdata=%h, expected stall=%b wreg=%b wd=%0d wdata=%h",
                     c, stallreq_o, wreg_o, wd_o, wdata_o, e.stall, e.wreg, e.wd, e.wdata);
         end
         @(posedge clk); #1;
      end
      rst = 1'b0;
   endtask
   task automatic test_alu;
      vec_t v [13];
      v = '{'{OP_ARITH, F_SUB, 32'd5, 32'd7}, '{OP_ARITH, F_ADD, 32'hFFFF_FFFF, 32'd1},
            '{OP_ARITH, F_SLT, 32'hFFFF_FFFF, 32'd1}, '{OP_ARITH, F_SLTU, 32'hFFFF_FFFF, 32'd1},
            '{OP_LOGIC, F_AND, 32'hF0F0_1234, 32'h0FF0_FF00}, '{OP_LOGIC, F_OR, 32'hF000_0001, 32'h000F_0010},
            '{OP_LOGIC, F_XOR, 32'hAAAA_5555, 32'hFFFF_0000}, '{OP_SHIFT, F_SLL, 32'd1, 32'h0000_003F},
            '{OP_SHIFT, F_SRL, 32'h8000_0000, 32'd4}, '{OP_SHIFT, F_SRA, 32'h8000_0000, 32'd4},
            '{OP_NOP, 4'd0, 32'd9, 32'd9}, '{OP_LOGIC, 4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
            '{OP_ARITH, 4'd7, 32'd3, 32'd4}};
      for (int i = 0; i < 13; i++) begin
         drive(v[i].op, v[i].f, v[i].a, v[i].b, 5'(i + 3), ~i[0]);
         sb.push_back('{model(v[i].op, v[i].f, v[i].a, v[i].b), 1'b1, 5'(i + 3), ~i[0], 1'b0});
         @(negedge clk);
         e = sb.pop_front(); checks++;
         if (stallreq_o !== e.stall || wreg_o !== e.wreg || wd_o !== e.wd || (e.dchk && wdata_o !== e.wdata)) begin
            errors++;
            $display("FAIL alu[%0d]: got stall=%b wreg=%b wd=%0d wdata=%h, expected stall=%b wreg=%b wd=%0d wdata=%h",
                     i, stallreq_o, wreg_o, wd_o, wdata_o, e.stall, e.wreg, e.wd, e.wdata);
         end
         @(posedge clk); #1;
      end
   endtask
   task automatic test_mul;
      vec_t v [6];
      v = '{'{OP_MULDIV, F_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, '{OP_MULDIV, F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
            '{OP_MULDIV, F_MUL, 32'h1234_5678, 32'h09AB_CDEF}, '{OP_MULDIV, F_MULHSU, 32'hFFFF_FFFF, 32'h0000_00FF},
            '{OP_MULDIV, F_MULH, 32'h8000_0000, 32'h8000_0000}, '{OP_MULDIV, 4'd8, 32'd6, 32'd7}};
      for (int i = 0; i < 6; i++) begin
         drive(v[i].op, v[i].f, v[i].a, v[i].b, 5'(i + 1), 1'b1);
         sb.push_back('{model(v[i].op, v[i].f, v[i].a, v[i].b), 1'b1, 5'(i + 1), 1'b1, 1'b0});
         @(negedge clk);
         e = sb.pop_front(); checks++;
         if (stallreq_o !== e.stall || wreg_o !== e.wreg || wd_o !== e.wd || (e.dchk && wdata_o !== e.wdata)) begin
            errors++;
            $display("FAIL mul[%0d]: got stall=%b wreg=%b wd=%0d wdata=%h, expected stall=%b wreg=%b wd=%0d wdata=%h",
                     i, stallreq_o, wreg_o, wd_o, wdata_o, e.stall, e.wreg, e.wd, e.wdata);
         end
         @(posedge clk); #1;
      end
   endtask
   task automatic test_div_special;
      dv_t v [6];
      v = '{'{F_DIVU, 32'd10, 32'd0, 32'hFFFF_FFFF, 1'b0}, '{F_REMU, 32'd10, 32'd0, 32'd10, 1'b0},
            '{F_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1'b0}, '{F_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1'b0},
            '{F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0}, '{F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0}};
      for (int i = 0; i < 6; i++) begin
         drive(OP_MULDIV, v[i].f, v[i].a, v[i].b, 5'd20, 1'b1);
         sb.push_back('{v[i].q, 1'b1, 5'd20, 1'b1, 1'b0});
         @(negedge clk);
         e = sb.pop_front(); checks++;
         if (stallreq_o !== e.stall || wreg_o !== e.wreg || wd_o !== e.wd || (e.dchk && wdata_o !== e.wdata)) begin
            errors++;
            $display("FAIL div_special[%0d]: got stall=%b wreg=%b wd=%0d wdata=%h, expected stall=%b wreg=%b wd=%0d wdata=%h",
                     i, stallreq_o, wreg_o, wd_o, wdata_o, e.stall, e.wreg, e.wd, e.wdata);
         end
         @(posedge clk); #1;
      end
   endtask
   task automatic test_div;
      dv_t v [8];
      v = '{'{F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1}, '{F_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0},
            '{F_DIVU, 32'd100, 32'd7, 32'd14, 1'b0}, '{F_REMU, 32'hFFFF_FFFF, 32'd10, 32'd5, 1'b1},
            '{F_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0}, '{F_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0},
            '{F_DIV, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0}, '{F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1}};
      for (int i = 0; i < 8; i++) begin
         drive(OP_MULDIV, v[i].f, v[i].a, v[i].b, 5'(i + 10), 1'b1);
         for (int c = 0; c <= 33; c++) begin
            sb.push_back('{v[i].q, c == 33, 5'(i + 10), c == 33, c != 33});
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if (stallreq_o !== e.stall || wreg_o !== e.wreg || wd_o !== e.wd || (e.dchk && wdata_o !== e.wdata)) begin
               errors++;
               $display("FAIL div[%0d] cycle %0d: got stall=%b wreg=%b wd=%0d wdata=%h, expected stall=%b wreg=%b wd=%0d wdata=%h",
                        i, c, stallreq_o, wreg_o, wd_o, wdata_o, e.stall, e.wreg, e.wd, e.wdata);
            end
            @(posedge clk); #1;
         end
         if (v[i].gap) begin
            drive(OP_NOP, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0);
            @(posedge clk); #1;
         end
      end
   endtask
   task automatic test_flush;
      drive(OP_MULDIV, F_DIV, 32'd1000, 32'd3, 5'd9, 1'b1);
      for (int c = 0; c <= 11; c++) begin
         if (c == 10) flush_i = 1'b1;
         if (c == 11) begin
            flush_i = 1'b0;
            drive(OP_ARITH, F_ADD, 32'd1, 32'd1, 5'd4, 1'b1);
         end
         sb.push_back(c == 11 ? '{32'd2, 1'b1, 5'd4, 1'b1, 1'b0} : '{32'd0, 1'b0, 5'd9, c == 10, c < 10});
         @(negedge clk);
         e = sb.pop_front(); checks++;
         if (stallreq_o !== e.stall || wreg_o !== e.wreg || wd_o !== e.wd || (e.dchk && wdata_o !== e.wdata)) begin
            errors++;
            $display("FAIL flush cycle %0d: got stall=%b wreg=%b wd=%0d wdata=%h, expected stall=%b wreg=%b wd=%0d wdata=%h",
                     c, stallreq_o, wreg_o, wd_o, wdata_o, e.stall, e.wreg, e.wd, e.wdata);
         end
         @(posedge clk); #1;
      end
   endtask
   task automatic test_reset_mid;
      drive(OP_MULDIV, F_DIVU, 32'd9, 32'd2, 5'd6, 1'b1);
      for (int c = 0; c < 7; c++) begin
         if (c == 5) rst = 1'b1;
         sb.push_back(c >= 5 ? '{32'd0, 1'b1, 5'd0, 1'b0, 1'b0} : '{32'd0, 1'b0, 5'd6, 1'b0, 1'b1});
         @(negedge clk);
         e = sb.pop_front(); checks++;
         if (stallreq_o !== e.stall || wreg_o !== e.wreg || wd_o !== e.wd || (e.dchk && wdata_o !== e.wdata)) begin
            errors++;
            $display("FAIL reset_mid cycle %0d: got stall=%b wreg=%b wd=%0d wdata=%h, expected stall=%b wreg=%b wd=%0d wdata=%h",
                     c, stallreq_o, wreg_o, wd_o, wdata_o, e.stall, e.wreg, e.wd, e.wdata);
         end
         @(posedge clk); #1;
      end
      rst = 1'b0;
      drive(OP_MULDIV, F_DIVU, 32'd100, 32'd7, 5'd7, 1'b1);
      for (int c = 0; c <= 33; c++) begin
         sb.push_back('{32'd14, c == 33, 5'd7, c == 33, c != 33});
         @(negedge clk);
         e = sb.pop_front(); checks++;
         if (stallreq_o !== e.stall || wreg_o !== e.wreg || wd_o !== e.wd || (e.dchk && wdata_o !== e.wdata)) begin
            errors++;
            $display("FAIL after_reset cycle %0d: got stall=%b wreg=%b wd=%0d wdata=%h, expected stall=%b wreg=%b wd=%0d wdata=%h",
                     c, stallreq_o, wreg_o, wd_o, wdata_o, e.stall, e.wreg, e.wd, e.wdata);
         end
         @(posedge clk); #1;
      end
      drive(OP_NOP, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end
   initial begin
      @(posedge clk); #1;
      test_reset;
      test_alu;
      test_mul;
      test_div_special;
      test_div;
      test_flush;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Reset rst, synchronous, active-high; clock clk.
REQ-002 clk  in  1  system clock, rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 aluop_i  in  `AluOpBus (3)  op class from ID/EX register: NOP=0, LOGIC=1, SHIFT=2, ARITH=3, MULDIV=4.
REQ-005 alufun_i  in  `AluFunBus (4)  sub-function: LOGIC AND/OR/XOR=0/1/2; SHIFT SLL/SRL/SRA=0/1/2; ARITH ADD/SUB/SLT/SLTU=0/1/2/3; MULDIV = RISC-V funct3 0..7 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
REQ-006 reg1_i, reg2_i  in  `RegBus (32)  operands.
REQ-007 wd_i  in  `RegAddrBus (5)  destination register; wreg_i  in  1  write enable.
REQ-008 flush_i  in  1  pipeline flush, aborts in-flight division.
REQ-009 wd_o  out  5, wreg_o  out  1, wdata_o  out  32  result to EX/MEM register.
REQ-010 stallreq_o  out  1  request to hold PC, IF/ID, ID/EX; ID/EX inputs hold stable while high.

Function
REQ-011 LOGIC, SHIFT, ARITH, MUL* ops: wdata_o valid combinationally in the same cycle; stallreq_o=0.
REQ-012 Shift amount = reg2_i[4:0]; SRA sign-fills; SLT signed, SLTU unsigned compare, result 0/1.
REQ-013 MUL returns low 32 bits; MULH/MULHSU/MULHU return high 32 bits of 64-bit product with signed*signed / signed*unsigned / unsigned*unsigned.
REQ-014 NOP or unknown encodings: wdata_o=0; wd_o/wreg_o pass through.
REQ-015 Divider FSM states IDLE, BUSY, DONE; IDLE after reset.
REQ-016 IDLE + DIV/DIVU/REM/REMU with nonzero divisor and not signed-overflow: stallreq_o=1, latch operands (absolute values for signed), counter=0, -> BUSY.
REQ-017 BUSY: one restoring shift-subtract step per cycle, stallreq_o=1; after step 31 (32 cycles) -> DONE.
REQ-018 DONE: wdata_o = quotient (DIV*) or remainder (REM*), sign-corrected (quotient negative iff operand signs differ; remainder takes dividend sign); stallreq_o=0; next cycle -> IDLE.
REQ-019 Total latency: divide op presented at cycle 0, result on wdata_o at cycle 33 with stallreq_o high cycles 0..32.
REQ-020 Divisor zero: no stall, same-cycle result; quotient 0xFFFFFFFF, remainder = dividend.
REQ-021 Signed overflow (0x80000000 / 0xFFFFFFFF, DIV/REM): no stall; quotient 0x80000000, remainder 0.
REQ-022 Back-to-back divides: second divide is recognized in IDLE the cycle after DONE.
REQ-023 flush_i in BUSY or DONE: -> IDLE next edge, stallreq_o=0 that cycle, no result; flush_i has priority over new divide start.
REQ-024 wd_o=wd_i, wreg_o=wreg_i in all non-reset cycles; wreg_o=0 while stallreq_o=1.

Reset
REQ-025 rst forces state IDLE, counter 0, internal dividend/divisor/quotient/remainder 0 at next edge.
REQ-026 While rst=1 all outputs are 0, including stallreq_o; reset mid-division discards the operation.

Structure
REQ-027 aluop/alufun encodings, bus widths and DIV state encodings live in defines.v.
REQ-028 Iterative divider is sub-module ex_div (start, signed, dividend, divisor, abort -> busy, done, quotient, remainder); ALU/mul logic stays in ex_stage.

Verification
REQ-029 ARITH SUB reg1=5, reg2=7, wd=3, wreg=1 -> same cycle wdata_o=0xFFFFFFFE, wd_o=3, wreg_o=1, stallreq_o=0.
REQ-030 MULH 0xFFFFFFFF * 0xFFFFFFFF -> wdata_o=0; MULHU same operands -> 0xFFFFFFFE.
REQ-031 DIV -7 / 2 held stable -> stallreq_o high cycles 0..32, cycle 33 wdata_o=0xFFFFFFFD; REM same -> 0xFFFFFFFF.
REQ-032 DIVU 10/0 -> same cycle 0xFFFFFFFF, no stall; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, no stall.
REQ-033 flush_i at BUSY cycle 10 -> stallreq_o=0 next cycle, FSM IDLE, subsequent ADD 1+1 -> 2 same cycle.
REQ-034 rst at BUSY cycle 5 -> outputs 0 during reset; after release, DIVU 100/7 -> 14 at cycle 33.
